// File: rtl/muldiv_sequencer_if.sv
// Command/result and shared-ALU bus of the RV32M mul/div sequencer.
// Master drives commands and ALU responses; the sequencer is the slave.
interface muldiv_sequencer_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        alu_req;
  logic        alu_gnt;
  logic [3:0]  alu_sel;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        alu_c;

  modport master (
    output start, op, rs1, rs2, alu_gnt, alu_result, alu_c,
    input  busy, done, result, alu_req, alu_sel, alu_a, alu_b
  );

  modport slave (
    input  start, op, rs1, rs2, alu_gnt, alu_result, alu_c,
    output busy, done, result, alu_req, alu_sel, alu_a, alu_b
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// RV32M MUL/MULHU/DIV/DIVU/REM/REMU on a borrowed ALU; 36 cycles at full grant, 1 on fast paths.
// Each cycle without alu_gnt in a request state stalls the FSM by one cycle; start is ignored while busy.
module muldiv_sequencer #(
  parameter logic [3:0] ALU_ADD_CODE = 4'd0,
  parameter logic [3:0] ALU_SUB_CODE = 4'd1,
  parameter int         XLEN         = 32
) (
  input logic               clk,
  input logic               rst_n,
  muldiv_sequencer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, PREP_A, PREP_B, ITER, FIX, DONE} state_t;

  state_t            state, state_nxt;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   x_q, y_q;
  logic [XLEN-1:0]   acc_hi, acc_lo;
  logic [XLEN-1:0]   res_q;
  logic              q_sgn, r_sgn;
  logic [4:0]        cnt;

  logic              in_legal, in_div, in_rem, in_signed, in_div0, in_ovf;
  logic              is_div, is_rem, is_signed;
  logic [XLEN:0]     div_sh;
  logic              div_acc;
  logic [XLEN:0]     mul_sum;
  logic              fix_neg;
  logic [XLEN-1:0]   fix_raw;

  logic              busy, done, alu_req;
  logic [3:0]        alu_sel;
  logic [XLEN-1:0]   alu_a, alu_b;

  assign in_legal  = bus.op[2] | ~bus.op[1];
  assign in_div    = bus.op[2];
  assign in_rem    = bus.op[2] & bus.op[1];
  assign in_signed = bus.op[2] & ~bus.op[0];
  assign in_div0   = in_div && (bus.rs2 == '0);
  assign in_ovf    = in_signed && (bus.rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2 == '1);

  assign is_div    = op_q[2];
  assign is_rem    = op_q[2] & op_q[1];
  assign is_signed = op_q[2] & ~op_q[0];

  // Restoring step: {R,Q} shifted left, R[32] forces acceptance of the subtract.
  assign div_sh  = {acc_hi, acc_lo[XLEN-1]};
  assign div_acc = div_sh[XLEN] || (div_sh[XLEN-1:0] >= y_q);
  assign mul_sum = acc_lo[0] ? {bus.alu_c, bus.alu_result} : {1'b0, acc_hi};

  assign fix_neg = (is_div && !is_rem && q_sgn) || (is_rem && r_sgn);
  assign fix_raw = (op_q == 3'b000 || op_q[2:1] == 2'b10) ? acc_lo : acc_hi;

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = (state == DONE);
    alu_req   = 1'b0;
    alu_sel   = 4'd0;
    alu_a     = '0;
    alu_b     = '0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (!in_legal || in_div0 || in_ovf) state_nxt = DONE;
          else                                state_nxt = PREP_A;
        end
      end
      PREP_A: begin
        alu_req = 1'b1;
        alu_sel = ALU_SUB_CODE;
        alu_b   = x_q;
        if (bus.alu_gnt) state_nxt = PREP_B;
      end
      PREP_B: begin
        alu_req = 1'b1;
        alu_sel = ALU_SUB_CODE;
        alu_b   = y_q;
        if (bus.alu_gnt) state_nxt = ITER;
      end
      ITER: begin
        alu_req = 1'b1;
        if (is_div) begin
          alu_sel = ALU_SUB_CODE;
          alu_a   = div_sh[XLEN-1:0];
          alu_b   = y_q;
        end else begin
          alu_sel = ALU_ADD_CODE;
          alu_a   = acc_hi;
          alu_b   = x_q;
        end
        if (bus.alu_gnt && cnt == 5'd31) state_nxt = FIX;
      end
      FIX: begin
        alu_req = 1'b1;
        alu_sel = ALU_SUB_CODE;
        alu_b   = is_rem ? acc_hi : acc_lo;
        if (bus.alu_gnt) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_q   <= '0;
      x_q    <= '0;
      y_q    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      res_q  <= '0;
      q_sgn  <= 1'b0;
      r_sgn  <= 1'b0;
      cnt    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_q  <= bus.op;
            x_q   <= bus.rs1;
            y_q   <= bus.rs2;
            q_sgn <= 1'b0;
            r_sgn <= 1'b0;
            cnt   <= '0;
            if (!in_legal)    res_q <= '0;
            else if (in_div0) res_q <= in_rem ? bus.rs1 : '1;
            else if (in_ovf)  res_q <= in_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
          end
        end
        PREP_A: begin
          if (bus.alu_gnt && is_signed) begin
            // Signs taken from the raw operands before the dividend is negated.
            q_sgn <= x_q[XLEN-1] ^ y_q[XLEN-1];
            r_sgn <= x_q[XLEN-1];
            if (x_q[XLEN-1]) x_q <= bus.alu_result;
          end
        end
        PREP_B: begin
          if (bus.alu_gnt) begin
            if (is_signed && y_q[XLEN-1]) y_q <= bus.alu_result;
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= is_div ? x_q : y_q;
          end
        end
        ITER: begin
          if (bus.alu_gnt) begin
            cnt <= cnt + 5'd1;
            if (is_div) begin
              acc_hi <= div_acc ? bus.alu_result : div_sh[XLEN-1:0];
              acc_lo <= {acc_lo[XLEN-2:0], div_acc};
            end else begin
              acc_hi <= mul_sum[XLEN:1];
              acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
            end
          end
        end
        FIX: begin
          if (bus.alu_gnt) res_q <= fix_neg ? bus.alu_result : fix_raw;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.result  = res_q;
  assign bus.alu_req = alu_req;
  assign bus.alu_sel = alu_sel;
  assign bus.alu_a   = alu_a;
  assign bus.alu_b   = alu_b;

endmodule
